// File: rtl/debug_link_pkg.sv
// ----------------------------------------------------------------------------
// debug_link_pkg
// Shared definitions for the debug serial link (sender and receiver).
//   DBG_WIDTH  : bits per frame, LSB sent first
//   dbg_state_t: link FSM states (IDLE, SHIFT, TAIL)
//   dbg_word_t : one frame word
// ----------------------------------------------------------------------------
package debug_link_pkg;

    localparam int DBG_WIDTH = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } dbg_state_t;

    typedef logic [DBG_WIDTH-1:0] dbg_word_t;

endpackage

// File: rtl/debug_sync2.sv
// ----------------------------------------------------------------------------
// debug_sync2
// Two-flop synchronizer for a single-bit signal; both flops reset to 0.
// Ports:
//   clk  in  destination clock
//   rst  in  asynchronous active-high reset
//   d    in  asynchronous input
//   q    out synchronized output (2 cycles of latency)
// ----------------------------------------------------------------------------
module debug_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debug_data_receiver.sv
// ----------------------------------------------------------------------------
// debug_data_receiver
// Deserializer for the debug serial link. Samples sin while sframe=1,
// rebuilds each LSB-first WIDTH-bit word and offers it on a valid/ack
// handshake. Flags short, long and overrun frames with sticky bits.
//
// Optional feature (macro DEBUG_RX_SYNC_EN): when defined, sin and sframe
// each pass through a 2-flop synchronizer before the FSM, delaying all
// frame-relative timing by 2 cycles. When undefined they feed the FSM
// directly.
//
// Ports:
//   clk        in   link clock
//   rst        in   asynchronous active-high reset
//   sin        in   serial data, LSB first
//   sframe     in   frame qualifier, high for WIDTH cycles per word
//   data_out   out  last complete word (data_out[k] = frame bit k)
//   valid      out  data_out holds an unconsumed word
//   ack        in   consumer accepts data_out
//   err_clr    in   synchronous clear of sticky error flags
//   err_short  out  sticky: frame ended before WIDTH bits
//   err_long   out  sticky: sframe stayed high after WIDTH bits
//   overrun    out  sticky: word completed while previous still pending
//   dbg_state  out  current FSM state (IDLE=0, SHIFT=1, TAIL=2)
//
// Handshake: valid rises on the edge that samples the last frame bit. It
// stays high until an edge where ack=1, and falls on that edge unless a new
// word is published on the same edge (then the new word is loaded and valid
// stays high). ack while valid=0 has no effect.
// ----------------------------------------------------------------------------
module debug_data_receiver
    import debug_link_pkg::*;
#(
    parameter int WIDTH = DBG_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sframe,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ack,
    input  logic             err_clr,
    output logic             err_short,
    output logic             err_long,
    output logic             overrun,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic sin_s;
    logic sframe_s;

`ifdef DEBUG_RX_SYNC_EN
    debug_sync2 u_sync_sin (
        .clk (clk),
        .rst (rst),
        .d   (sin),
        .q   (sin_s)
    );

    debug_sync2 u_sync_sframe (
        .clk (clk),
        .rst (rst),
        .d   (sframe),
        .q   (sframe_s)
    );
`else
    assign sin_s    = sin;
    assign sframe_s = sframe;
`endif

    dbg_state_t       state;
    dbg_state_t       state_nxt;
    logic [CNT_W-1:0] count;

    // Only bits WIDTH-1..1 are stored: the bit that would sit in position 0
    // is always shifted out on the publishing edge, which takes its
    // replacement straight from sin_s.
    logic [WIDTH-1:1] shreg;
    logic [WIDTH-1:0] word;

    logic capture;
    logic publish;
    logic short_evt;
    logic long_evt;

    assign word      = {sin_s, shreg[WIDTH-1:1]};
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        publish   = 1'b0;
        short_evt = 1'b0;
        long_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (sframe_s) begin
                    capture   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sframe_s) begin
                    capture = 1'b1;
                    if (count == LAST) begin
                        publish   = 1'b1;
                        state_nxt = TAIL;
                    end
                end else begin
                    short_evt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            TAIL: begin
                // Bits past WIDTH are not sampled; wait for the frame to end.
                if (sframe_s) begin
                    long_evt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            count <= '0;
        end else if (short_evt) begin
            shreg <= '0;
            count <= '0;
        end else if (capture) begin
            shreg <= word[WIDTH-1:1];
            count <= publish ? '0 : count + 1'b1;
        end
    end

    // Output word and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (publish && (!valid || ack)) begin
            data_out <= word;
            valid    <= 1'b1;
        end else if (valid && ack) begin
            valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event wins over err_clr on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (short_evt) begin
                err_short <= 1'b1;
            end else if (err_clr) begin
                err_short <= 1'b0;
            end

            if (long_evt) begin
                err_long <= 1'b1;
            end else if (err_clr) begin
                err_long <= 1'b0;
            end

            if (publish && valid && !ack) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_data_receiver.sv
// ----------------------------------------------------------------------------
// tb_debug_data_receiver
// Directed, table-driven bench for debug_data_receiver, plus hand-written
// sequences for reset-mid-frame and publish timing.
// ----------------------------------------------------------------------------
module tb_debug_data_receiver;

`ifdef DEBUG_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic        sin;
    logic        sframe;
    logic [39:0] data_out;
    logic        valid;
    logic        ack;
    logic        err_clr;
    logic        err_short;
    logic        err_long;
    logic        overrun;
    logic [1:0]  dbg_state;

    int n_total;
    int n_pass;

    debug_data_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sframe    (sframe),
        .data_out  (data_out),
        .valid     (valid),
        .ack       (ack),
        .err_clr   (err_clr),
        .err_short (err_short),
        .err_long  (err_long),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic f, input logic s, input logic a, input logic c);
        sframe  = f;
        sin     = s;
        ack     = a;
        err_clr = c;
        @(posedge clk);
        #1;
    endtask

    // Send nbits with sframe=1 (bits past 40 are 1s), then LAT+1 idle cycles
    // so the FSM has seen the frame end. ack/err_clr pulse at cycle index
    // ack_at/clr_at (-1 for none).
    task automatic run_frame(input logic [39:0] w, input int nbits,
                             input int ack_at, input int clr_at);
        for (int k = 0; k < nbits + LAT + 1; k++) begin
            logic b;
            if (k < nbits) b = (k < 40) ? w[k] : 1'b1;
            else           b = 1'b0;
            cyc(k < nbits, b, k == ack_at, k == clr_at);
        end
    endtask

    typedef struct {
        logic [39:0] w;
        int          nbits;
        int          ack_at;
        int          clr_at;
        bit          ack_after;
        logic [39:0] exp_data;
        logic        exp_valid;
        logic        exp_short;
        logic        exp_long;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        n_total = 0;
        n_pass  = 0;
        sin     = 1'b0;
        sframe  = 1'b0;
        ack     = 1'b0;
        err_clr = 1'b0;
        rst     = 1'b0;
        #1 rst  = 1'b1;

        //            w           nbits ack_at   clr_at   ackA exp_data     v  s  l  o
        vecs[0] = '{40'hA999999991, 40, 40+LAT,  -1,      0, 40'hA999999991, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{40'hE999999993, 40, -1,      -1,      1, 40'hE999999993, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{40'h123456789A, 17, -1,      17+LAT,  0, 40'hE999999993, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{40'h5A5A5A5A5A, 40, -1,      0,       1, 40'h5A5A5A5A5A, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{40'h0F0F0F0F0F, 43, -1,      -1,      1, 40'h0F0F0F0F0F, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{40'h1122334455, 40, -1,      0,       0, 40'h1122334455, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{40'h66778899AA, 40, -1,      -1,      1, 40'h1122334455, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{40'h0102030405, 40, -1,      0,       0, 40'h0102030405, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{40'hCAFEBABE12, 40, 39+LAT,  -1,      1, 40'hCAFEBABE12, 1'b1, 1'b0, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  data_out,  40'h0);
        chk("rst_valid", 40'(valid), 40'h0);
        chk("rst_errs",  40'({err_short, err_long, overrun}), 40'h0);
        chk("rst_state", 40'(dbg_state), 40'h0);
        rst = 1'b0;

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].w, vecs[i].nbits, vecs[i].ack_at, vecs[i].clr_at);
            chk($sformatf("v%0d_data", i),  data_out,            vecs[i].exp_data);
            chk($sformatf("v%0d_valid", i), 40'(valid),          40'(vecs[i].exp_valid));
            chk($sformatf("v%0d_short", i), 40'(err_short),      40'(vecs[i].exp_short));
            chk($sformatf("v%0d_long", i),  40'(err_long),       40'(vecs[i].exp_long));
            chk($sformatf("v%0d_ovr", i),   40'(overrun),        40'(vecs[i].exp_ovr));
            chk($sformatf("v%0d_state", i), 40'(dbg_state),      40'h0);
            if (vecs[i].ack_after) begin
                cyc(1'b0, 1'b0, 1'b1, 1'b0);
                chk($sformatf("v%0d_ack", i), 40'(valid), 40'h0);
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        // ---------------- reset mid-frame ----------------
        // Pending word plus a long frame so there is state to lose.
        run_frame(40'hABCDEF0123, 42, -1, -1);
        chk("pre_rst_valid", 40'(valid), 40'h1);
        chk("pre_rst_long",  40'(err_long), 40'h1);
        for (int k = 0; k < 20; k++) begin
            logic [39:0] pw;
            pw = 40'h13579BDF02;
            cyc(1'b1, pw[k], 1'b0, 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_data",  data_out, 40'h0);
        chk("mid_rst_valid", 40'(valid), 40'h0);
        chk("mid_rst_errs",  40'({err_short, err_long, overrun}), 40'h0);
        chk("mid_rst_state", 40'(dbg_state), 40'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Fresh frame after reset, checking publish latency.
        begin
            logic [39:0] fw;
            fw = 40'h2468ACE135;
            for (int k = 0; k < 40 + LAT + 1; k++) begin
                cyc(k < 40, (k < 40) ? fw[k] : 1'b0, 1'b0, 1'b0);
                if (k == 38 + LAT) chk("lat_valid_early", 40'(valid), 40'h0);
                if (k == 39 + LAT) chk("lat_valid_now",   40'(valid), 40'h1);
            end
            chk("post_rst_data", data_out, 40'h2468ACE135);
            chk("post_rst_errs", 40'({err_short, err_long, overrun}), 40'h0);
        end

        // ack while valid=0 is ignored: consume, then ack again.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_ack_valid", 40'(valid), 40'h0);
        chk("idle_ack_data",  data_out,   40'h2468ACE135);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
